// File: rtl/proc_io_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// proc_io_ctrl_pkg
// Shared definitions for the processor I/O controller:
//   - default input/output port counts
//   - lowest-set-bit select and multi-hot detection used on the processor
//     strobes (req_in / out_en)
// The helpers work on a fixed 32-bit vector; callers widen their strobe with a
// cast and narrow the result back, so port counts up to 32 are supported.
// -----------------------------------------------------------------------------
package proc_io_ctrl_pkg;

    localparam int DEF_NUIOIN = 4;
    localparam int DEF_NUIOOU = 4;

    // Width of the vector the select helpers operate on.
    localparam int SEL_W = 32;

    // Keep only the lowest set bit of v (two's-complement isolate trick).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [SEL_W-1:0] v);
        return v & (~v + SEL_W'(1));
    endfunction

    // True when more than one bit of v is set.
    function automatic logic multi_hot(input logic [SEL_W-1:0] v);
        return (v & (v - SEL_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// -----------------------------------------------------------------------------
// io_fifo
// Single-clock FIFO with a combinational head. Used for both the producer-side
// (input) and consumer-side (output) queues of proc_io_ctrl.
//
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, empties the FIFO
//   push   : write request; accepted when not full, or when full with a pop
//            on the same edge
//   din    : write data
//   pop    : read request; ignored when empty
//   full   : count == DEPTH
//   empty  : count == 0
//   head   : oldest entry (valid only when !empty)
//
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = mem[rd_ptr_reg];

    // A pop from an empty FIFO is a no-op; a push into a full FIFO only lands
    // when the same edge frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset: stale contents are never observable because
    // the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

endmodule

// File: rtl/proc_io_ctrl.sv
// -----------------------------------------------------------------------------
// proc_io_ctrl
// Bridges streaming producers/consumers to a processor with strobe-based I/O.
//
// Input side (NUIOIN ports):
//   src_data/src_valid/src_ready : per-port valid/ready producer stream into
//                                  an io_fifo (ready = not full)
//   req_in                       : one-hot read strobe; the selected FIFO head
//                                  appears combinationally on io_in and pops on
//                                  the same edge. An empty port returns the last
//                                  value popped from it (hold) and flags err_udf.
// Output side (NUIOOU ports):
//   out_en/io_out                : one-hot write strobe and data into an io_fifo
//   snk_data/snk_valid/snk_ready : per-port valid/ready consumer stream
//                                  (valid = not empty)
// Error flags (sticky until err_clr, a new event in the clearing cycle wins):
//   err_udf : read of an empty input port
//   err_ovf : write to a full output port that was not draining that cycle
//   err_sel : multi-hot req_in or out_en (lowest index is still serviced)
// clk / rst : single clock, synchronous active-high reset.
// -----------------------------------------------------------------------------
module proc_io_ctrl
    import proc_io_ctrl_pkg::*;
#(
    parameter int NUIOIN = DEF_NUIOIN,
    parameter int NUIOOU = DEF_NUIOOU,
    parameter int NBIN   = 12,
    parameter int NBOUT  = 21,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    // producer side
    input  logic [NUIOIN*NBIN-1:0]  src_data,
    input  logic [NUIOIN-1:0]       src_valid,
    output logic [NUIOIN-1:0]       src_ready,
    // processor read port
    input  logic [NUIOIN-1:0]       req_in,
    output logic [NBIN-1:0]         io_in,
    // processor write port
    input  logic [NUIOOU-1:0]       out_en,
    input  logic [NBOUT-1:0]        io_out,
    // consumer side
    output logic [NUIOOU*NBOUT-1:0] snk_data,
    output logic [NUIOOU-1:0]       snk_valid,
    input  logic [NUIOOU-1:0]       snk_ready,
    // error reporting
    output logic [NUIOIN-1:0]       err_udf,
    output logic [NUIOOU-1:0]       err_ovf,
    output logic                    err_sel,
    input  logic                    err_clr
);

    // -------------------------------------------------------------------------
    // Strobe decode: only the lowest set bit of each strobe is acted on.
    // -------------------------------------------------------------------------
    logic [NUIOIN-1:0] req_sel;
    logic [NUIOOU-1:0] wr_sel;
    logic              sel_set;

    assign req_sel = NUIOIN'(lowest_set(SEL_W'(req_in)));
    assign wr_sel  = NUIOOU'(lowest_set(SEL_W'(out_en)));
    assign sel_set = multi_hot(SEL_W'(req_in)) | multi_hot(SEL_W'(out_en));

    // -------------------------------------------------------------------------
    // Input side
    // -------------------------------------------------------------------------
    logic [NUIOIN-1:0] in_full;
    logic [NUIOIN-1:0] in_empty;
    logic [NUIOIN-1:0] in_push;
    logic [NUIOIN-1:0] in_pop;
    logic [NUIOIN-1:0] udf_set;
    logic [NBIN-1:0]   in_head [NUIOIN];
    logic [NBIN-1:0]   hold_reg [NUIOIN];
    logic [NBIN-1:0]   rd_term [NUIOIN];

    assign src_ready = ~in_full;

    genvar gi;
    generate
        for (gi = 0; gi < NUIOIN; gi++) begin : g_in
            // Gate with ready so a full FIFO never absorbs a beat the producer
            // thinks was refused, even if a read frees a slot that same edge.
            assign in_push[gi] = src_valid[gi] & ~in_full[gi];
            assign in_pop[gi]  = req_sel[gi] & ~in_empty[gi];
            assign udf_set[gi] = req_sel[gi] & in_empty[gi];

            io_fifo #(
                .WIDTH (NBIN),
                .DEPTH (DEPTH)
            ) u_in_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (in_push[gi]),
                .din   (src_data[gi*NBIN +: NBIN]),
                .pop   (in_pop[gi]),
                .full  (in_full[gi]),
                .empty (in_empty[gi]),
                .head  (in_head[gi])
            );

            // Last value handed to the processor from this port; replayed on
            // an underflowing read. A same-cycle push is deliberately not
            // forwarded: the empty flag is from the registered count.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_reg[gi] <= '0;
                end else if (in_pop[gi]) begin
                    hold_reg[gi] <= in_head[gi];
                end
            end

            // Per-port contribution to the read mux; zero unless selected.
            assign rd_term[gi] = !req_sel[gi] ? '0 :
                                 (in_empty[gi] ? hold_reg[gi] : in_head[gi]);
        end
    endgenerate

    // req_sel is at most one-hot, so an OR of the gated terms is the mux.
    always_comb begin
        io_in = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            io_in = io_in | rd_term[k];
        end
    end

    // -------------------------------------------------------------------------
    // Output side
    // -------------------------------------------------------------------------
    logic [NUIOOU-1:0] out_full;
    logic [NUIOOU-1:0] out_empty;
    logic [NUIOOU-1:0] out_pop;
    logic [NUIOOU-1:0] ovf_set;

    assign snk_valid = ~out_empty;

    generate
        for (gi = 0; gi < NUIOOU; gi++) begin : g_out
            assign out_pop[gi] = ~out_empty[gi] & snk_ready[gi];
            // A full FIFO that drains on this edge still takes the write.
            assign ovf_set[gi] = wr_sel[gi] & out_full[gi] & ~out_pop[gi];

            io_fifo #(
                .WIDTH (NBOUT),
                .DEPTH (DEPTH)
            ) u_out_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (wr_sel[gi]),
                .din   (io_out),
                .pop   (out_pop[gi]),
                .full  (out_full[gi]),
                .empty (out_empty[gi]),
                .head  (snk_data[gi*NBOUT +: NBOUT])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Sticky error flags: clear first, then OR in this cycle's events so a
    // coincident event survives the clear.
    // -------------------------------------------------------------------------
    logic [NUIOIN-1:0] err_udf_reg;
    logic [NUIOIN-1:0] err_udf_next;
    logic [NUIOOU-1:0] err_ovf_reg;
    logic [NUIOOU-1:0] err_ovf_next;
    logic              err_sel_reg;
    logic              err_sel_next;

    always_comb begin
        err_udf_next = (err_clr ? '0 : err_udf_reg) | udf_set;
        err_ovf_next = (err_clr ? '0 : err_ovf_reg) | ovf_set;
        err_sel_next = (err_clr ? 1'b0 : err_sel_reg) | sel_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_udf_reg <= '0;
            err_ovf_reg <= '0;
            err_sel_reg <= 1'b0;
        end else begin
            err_udf_reg <= err_udf_next;
            err_ovf_reg <= err_ovf_next;
            err_sel_reg <= err_sel_next;
        end
    end

    assign err_udf = err_udf_reg;
    assign err_ovf = err_ovf_reg;
    assign err_sel = err_sel_reg;

endmodule

// File: tb/tb_proc_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_proc_io_ctrl
// Scoreboard bench: every driven cycle runs a queue-based reference model that
// pushes expected processor read data and expected consumer data into queues;
// a negedge monitor pops and compares whenever the DUT presents a read or a
// consumer handshake, and also compares ready/valid/flag status.
// -----------------------------------------------------------------------------
module tb_proc_io_ctrl;

    localparam int NI    = 4;
    localparam int NO    = 4;
    localparam int NBIN  = 12;
    localparam int NBOUT = 21;
    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NI*NBIN-1:0]    src_data;
    logic [NI-1:0]         src_valid;
    logic [NI-1:0]         src_ready;
    logic [NI-1:0]         req_in;
    logic [NBIN-1:0]       io_in;
    logic [NO-1:0]         out_en;
    logic [NBOUT-1:0]      io_out;
    logic [NO*NBOUT-1:0]   snk_data;
    logic [NO-1:0]         snk_valid;
    logic [NO-1:0]         snk_ready;
    logic [NI-1:0]         err_udf;
    logic [NO-1:0]         err_ovf;
    logic                  err_sel;
    logic                  err_clr;

    always #5 clk = ~clk;

    proc_io_ctrl #(
        .NUIOIN (NI),
        .NUIOOU (NO),
        .NBIN   (NBIN),
        .NBOUT  (NBOUT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .req_in    (req_in),
        .io_in     (io_in),
        .out_en    (out_en),
        .io_out    (io_out),
        .snk_data  (snk_data),
        .snk_valid (snk_valid),
        .snk_ready (snk_ready),
        .err_udf   (err_udf),
        .err_ovf   (err_ovf),
        .err_sel   (err_sel),
        .err_clr   (err_clr)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    logic [NBIN-1:0]  in_q    [NI][$];
    logic [NBIN-1:0]  hold_m  [NI];
    int               out_cnt [NO];
    logic [NBOUT-1:0] exp_snk [NO][$];
    logic [NBIN-1:0]  exp_io  [$];
    logic [NI-1:0]    m_udf;
    logic [NO-1:0]    m_ovf;
    logic             m_sel;

    // status the DUT should show during the current cycle
    logic [NI-1:0]    cur_src_ready = '1;
    logic [NO-1:0]    cur_snk_valid = '0;
    logic [NI-1:0]    cur_udf = '0;
    logic [NO-1:0]    cur_ovf = '0;
    logic             cur_sel = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lowest_idx(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Apply the currently driven inputs to the model, then advance one clock.
    task automatic cycle();
        int              s;
        int              w;
        int              pre_in [NI];
        bit              pop_o  [NO];
        logic [NBIN-1:0] v;
        logic [NI-1:0]   udf_s;
        logic [NO-1:0]   ovf_s;
        logic            sel_s;

        for (int k = 0; k < NI; k++) cur_src_ready[k] = (in_q[k].size() < DEPTH);
        for (int k = 0; k < NO; k++) cur_snk_valid[k] = (out_cnt[k] > 0);
        cur_udf = m_udf;
        cur_ovf = m_ovf;
        cur_sel = m_sel;

        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                in_q[k].delete();
                hold_m[k] = '0;
            end
            for (int k = 0; k < NO; k++) begin
                out_cnt[k] = 0;
                exp_snk[k].delete();
            end
            exp_io.delete();
            m_udf = '0;
            m_ovf = '0;
            m_sel = 1'b0;
        end else begin
            udf_s = '0;
            ovf_s = '0;
            sel_s = ($countones(req_in) > 1) || ($countones(out_en) > 1);
            for (int k = 0; k < NI; k++) pre_in[k] = in_q[k].size();

            s = lowest_idx(32'(req_in), NI);
            if (s >= 0) begin
                if (pre_in[s] > 0) begin
                    v = in_q[s].pop_front();
                    hold_m[s] = v;
                end else begin
                    v = hold_m[s];
                    udf_s[s] = 1'b1;
                end
                exp_io.push_back(v);
            end
            for (int k = 0; k < NI; k++) begin
                if (src_valid[k] && pre_in[k] < DEPTH) in_q[k].push_back(src_data[k*NBIN +: NBIN]);
            end

            for (int k = 0; k < NO; k++) pop_o[k] = (out_cnt[k] > 0) && snk_ready[k];
            w = lowest_idx(32'(out_en), NO);
            if (w >= 0) begin
                if (out_cnt[w] < DEPTH || pop_o[w]) begin
                    exp_snk[w].push_back(io_out);
                    out_cnt[w]++;
                end else begin
                    ovf_s[w] = 1'b1;
                end
            end
            for (int k = 0; k < NO; k++) if (pop_o[k]) out_cnt[k]--;

            m_udf = (err_clr ? '0 : m_udf) | udf_s;
            m_ovf = (err_clr ? '0 : m_ovf) | ovf_s;
            m_sel = (err_clr ? 1'b0 : m_sel) | sel_s;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("src_ready", 64'(src_ready), 64'(cur_src_ready));
            chk("snk_valid", 64'(snk_valid), 64'(cur_snk_valid));
            chk("err_udf", 64'(err_udf), 64'(cur_udf));
            chk("err_ovf", 64'(err_ovf), 64'(cur_ovf));
            chk("err_sel", 64'(err_sel), 64'(cur_sel));
            if (req_in != '0) begin
                $display("read  req_in=%b io_in=%0h", req_in, io_in);
                if (exp_io.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL io_in_read: got %0h expected none queued", io_in);
                end else begin
                    chk("io_in_read", 64'(io_in), 64'(exp_io.pop_front()));
                end
            end else begin
                chk("io_in_idle", 64'(io_in), 64'd0);
            end
            for (int k = 0; k < NO; k++) begin
                if (snk_valid[k] && snk_ready[k]) begin
                    $display("drain port=%0d snk_data=%0h", k, snk_data[k*NBOUT +: NBOUT]);
                    if (exp_snk[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL snk_data: port %0d got %0h expected none queued",
                                 k, snk_data[k*NBOUT +: NBOUT]);
                    end else begin
                        chk("snk_data", 64'(snk_data[k*NBOUT +: NBOUT]), 64'(exp_snk[k].pop_front()));
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        src_valid = '0;
        req_in    = '0;
        out_en    = '0;
        err_clr   = 1'b0;
    endtask

    task automatic push_in(input int k, input logic [NBIN-1:0] v);
        src_valid    = '0;
        src_valid[k] = 1'b1;
        src_data[k*NBIN +: NBIN] = v;
        cycle();
        src_valid = '0;
    endtask

    task automatic read_expect(input int k, input logic [NBIN-1:0] v);
        req_in    = '0;
        req_in[k] = 1'b1;
        #2;
        chk("io_in_directed", 64'(io_in), 64'(v));
        cycle();
        req_in = '0;
    endtask

    task automatic write_out(input int k, input logic [NBOUT-1:0] v);
        out_en    = '0;
        out_en[k] = 1'b1;
        io_out    = v;
        cycle();
        out_en = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NBIN-1:0] a;
        logic [NBIN-1:0] b;
        int              r;

        for (int k = 0; k < NI; k++) hold_m[k] = '0;
        for (int k = 0; k < NO; k++) out_cnt[k] = 0;
        m_udf = '0;
        m_ovf = '0;
        m_sel = 1'b0;
        rst = 1'b1;
        src_data = '0;
        io_out = '0;
        snk_ready = '1;
        idle();
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // reset state
        chk("rst_src_ready", 64'(src_ready), 64'hF);
        chk("rst_snk_valid", 64'(snk_valid), 64'h0);
        chk("rst_io_in", 64'(io_in), 64'h0);
        chk("rst_flags", 64'({err_udf, err_ovf, err_sel}), 64'h0);

        // three values through port 0
        push_in(0, NBIN'(5));
        push_in(0, NBIN'(7));
        push_in(0, NBIN'(-3));
        chk("p0_ready", 64'(src_ready[0]), 64'd1);
        read_expect(0, NBIN'(5));
        read_expect(0, NBIN'(7));
        read_expect(0, 12'hFFD);
        chk("p0_ready_after", 64'(src_ready[0]), 64'd1);

        // fill port 2, refused fifth beat, one read frees a slot
        for (int i = 0; i < DEPTH; i++) push_in(2, NBIN'($urandom));
        chk("p2_full", 64'(src_ready[2]), 64'd0);
        push_in(2, NBIN'(12'h555));
        chk("p2_still_full", 64'(src_ready[2]), 64'd0);
        req_in = 4'b0100;
        cycle();
        req_in = '0;
        chk("p2_ready_again", 64'(src_ready[2]), 64'd1);
        for (int i = 0; i < DEPTH - 1; i++) begin
            req_in = 4'b0100;
            cycle();
        end
        req_in = '0;

        // underflow on port 1 replays the hold value
        push_in(1, NBIN'(9));
        read_expect(1, NBIN'(9));
        read_expect(1, NBIN'(9));
        chk("udf_set", 64'(err_udf), 64'h2);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("udf_clr", 64'(err_udf), 64'h0);
        // clear and a new underflow in the same cycle: the new event wins
        req_in = 4'b0010;
        err_clr = 1'b1;
        cycle();
        idle();
        chk("udf_clr_race", 64'(err_udf), 64'h2);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;

        // overflow on output port 3
        snk_ready = '0;
        for (int i = 1; i <= 5; i++) write_out(3, NBOUT'(i));
        chk("ovf_set", 64'(err_ovf[3]), 64'd1);
        snk_ready = 4'b1000;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("snk3_data", 64'(snk_data[3*NBOUT +: NBOUT]), 64'(i));
            cycle();
        end
        chk("snk3_drained", 64'(snk_valid[3]), 64'd0);
        snk_ready = '1;
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;

        // multi-hot read strobe services only the lowest port
        a = NBIN'(12'h0B1);
        b = NBIN'(12'h0C2);
        src_valid = 4'b0110;
        src_data[1*NBIN +: NBIN] = a;
        src_data[2*NBIN +: NBIN] = b;
        cycle();
        src_valid = '0;
        req_in = 4'b0110;
        #2;
        chk("multi_io_in", 64'(io_in), 64'(a));
        cycle();
        req_in = '0;
        chk("multi_err_sel", 64'(err_sel), 64'd1);
        chk("multi_no_udf", 64'(err_udf), 64'h0);
        read_expect(2, b);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;

        // reset with both directions half full and flags set
        snk_ready = '0;
        src_valid = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            src_data = {NI{NBIN'($urandom)}};
            cycle();
        end
        src_valid = '0;
        write_out(0, NBOUT'(21'h1234));
        write_out(0, NBOUT'(21'h1235));
        write_out(1, NBOUT'(21'h2234));
        write_out(1, NBOUT'(21'h2235));
        req_in = 4'b1000;
        cycle();
        req_in = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst2_snk_valid", 64'(snk_valid), 64'h0);
        chk("rst2_src_ready", 64'(src_ready), 64'hF);
        chk("rst2_flags", 64'({err_udf, err_ovf, err_sel}), 64'h0);
        snk_ready = '1;

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(149) == 0);
            src_valid = NI'($urandom);
            for (int k = 0; k < NI; k++) src_data[k*NBIN +: NBIN] = NBIN'($urandom);
            r = $urandom_range(9);
            if (r < 4)      req_in = '0;
            else if (r < 9) req_in = NI'(1 << $urandom_range(NI - 1));
            else            req_in = NI'($urandom);
            r = $urandom_range(9);
            if (r < 4)      out_en = '0;
            else if (r < 9) out_en = NO'(1 << $urandom_range(NO - 1));
            else            out_en = NO'($urandom);
            io_out = NBOUT'($urandom);
            snk_ready = NO'($urandom);
            err_clr = ($urandom_range(15) == 0);
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
